// File: rtl/lane_pkg.sv
// Shared types and constants for the lane scroller slice.
package lane_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HIT
  } lane_state_t;

  localparam logic [7:0]  LFSR_SEED    = 8'hA5;
  // Feedback taps for x^8+x^6+x^5+x^4+1 in shift-left Fibonacci form.
  localparam logic [7:0]  LFSR_TAPS    = 8'hB8;
  localparam int unsigned DEFAULT_COLS = 16;

endpackage

// File: rtl/lane_lfsr.sv
// Spawn-bit generator for lane_scroller; only exists when LANE_SPAWN_LFSR_EN is defined.
`ifdef LANE_SPAWN_LFSR_EN
module lane_lfsr
  import lane_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       advance,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = LFSR_SEED;
    end else if (advance) begin
      q_d = {q_q[6:0], ^(q_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q <= LFSR_SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule
`endif

// File: rtl/lane_scroller.sv
// One scrolling obstacle lane with frog collision detection.
// Define LANE_SPAWN_LFSR_EN to feed new cells from an LFSR instead of rotating.
module lane_scroller
  import lane_pkg::*;
#(
  parameter int unsigned          COLS           = DEFAULT_COLS,
  parameter int unsigned          TICKS_PER_STEP = 4,
  parameter logic [COLS-1:0]      INIT_PATTERN   = COLS'(16'h0003)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    load,
  input  logic [COLS-1:0]         load_pattern,
  input  logic                    dir,
  input  logic [$clog2(COLS)-1:0] frog_col,
  input  logic                    frog_in_lane,
  output logic [COLS-1:0]         row_out,
  output logic                    step,
  output logic                    collision,
  output logic                    running
);

  localparam logic [7:0] TERM_CNT = 8'(TICKS_PER_STEP - 1);

  lane_state_t     state_q, state_d;
  logic [COLS-1:0] row_q, row_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            step_q, step_d;
  logic            coll_q, coll_d;
  logic            shift_en;
  logic            in_bit;
  logic            hit;

`ifdef LANE_SPAWN_LFSR_EN
  logic [7:0] lfsr_q;

  lane_lfsr u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .advance (shift_en),
    .q       (lfsr_q)
  );

  assign in_bit = lfsr_q[0];
`else
  assign in_bit = dir ? row_q[0] : row_q[COLS-1];
`endif

  // Out-of-range columns are masked before the row is indexed.
  assign hit = frog_in_lane && (32'(frog_col) < COLS) && row_q[frog_col];

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    step_d   = 1'b0;
    coll_d   = coll_q;
    shift_en = 1'b0;
    if (load) begin
      row_d   = load_pattern;
      cnt_d   = '0;
      coll_d  = 1'b0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) state_d = RUN;
        RUN: begin
          if (hit) begin
            state_d = HIT;
            coll_d  = 1'b1;
          end else if (tick && !pause) begin
            if (cnt_q == TERM_CNT) begin
              shift_en = 1'b1;
              cnt_d    = '0;
              step_d   = 1'b1;
              row_d    = dir ? {in_bit, row_q[COLS-1:1]} : {row_q[COLS-2:0], in_bit};
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        HIT: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= INIT_PATTERN;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      coll_q  <= coll_d;
    end
  end

  assign row_out   = row_q;
  assign step      = step_q;
  assign collision = coll_q;
  assign running   = (state_q == RUN);

endmodule

// File: tb/tb_lane_scroller.sv
// Self-checking bench for lane_scroller: directed scenarios plus random traffic against a lane model.
module tb_lane_scroller;

  localparam int TPS = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        tick, start, pause, load, dir, frog_in_lane;
  logic [15:0] load_pattern;
  logic [3:0]  frog_col;
  logic [15:0] row_out;
  logic        step, collision, running;

  logic        b_tick, b_start, b_pause, b_load, b_dir, b_fil;
  logic [11:0] b_pat;
  logic [3:0]  b_col;
  logic [11:0] b_row;
  logic        b_step, b_coll, b_run;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m_row;
  int          m_cnt;
  bit          m_run, m_hit, m_step;

  always #5 clock = ~clock;

  lane_scroller #(.COLS(16), .TICKS_PER_STEP(4), .INIT_PATTERN(16'h0003)) dut (
    .clock(clock), .reset(reset), .tick(tick), .start(start), .pause(pause),
    .load(load), .load_pattern(load_pattern), .dir(dir), .frog_col(frog_col),
    .frog_in_lane(frog_in_lane), .row_out(row_out), .step(step),
    .collision(collision), .running(running)
  );

  // Narrow lane with single-tick stepping: frog columns 12..15 lie outside the lane.
  lane_scroller #(.COLS(12), .TICKS_PER_STEP(1), .INIT_PATTERN(12'hFFF)) dut2 (
    .clock(clock), .reset(reset), .tick(b_tick), .start(b_start), .pause(b_pause),
    .load(b_load), .load_pattern(b_pat), .dir(b_dir), .frog_col(b_col),
    .frog_in_lane(b_fil), .row_out(b_row), .step(b_step),
    .collision(b_coll), .running(b_run)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rot16(input logic [15:0] r, input logic d);
    return d ? ((r >> 1) | (r << 15)) : ((r << 1) | (r >> 15));
  endfunction

  function automatic logic [11:0] rotl12(input logic [11:0] r);
    return (r << 1) | (r >> 11);
  endfunction

  task automatic model_reset();
    m_row = 16'h0003; m_cnt = 0; m_run = 0; m_hit = 0; m_step = 0;
  endtask

  // Lane behaviour applied to the inputs present at the coming edge.
  task automatic model_edge();
    m_step = 0;
    if (load) begin
      m_row = load_pattern; m_cnt = 0; m_run = 0; m_hit = 0;
    end else if (m_hit) begin
      m_hit = 1;
    end else if (!m_run) begin
      if (start) m_run = 1;
    end else if (frog_in_lane && m_row[frog_col]) begin
      m_run = 0; m_hit = 1;
    end else if (tick && !pause) begin
      m_cnt++;
      if (m_cnt == TPS) begin
        m_cnt = 0; m_row = rot16(m_row, dir); m_step = 1;
      end
    end
  endtask

  task automatic cyc(input string tag);
    model_edge();
    @(posedge clock);
    #1;
    check({tag, ".row"},  32'(row_out),   32'(m_row));
    check({tag, ".step"}, 32'(step),      32'(m_step));
    check({tag, ".coll"}, 32'(collision), 32'(m_hit));
    check({tag, ".run"},  32'(running),   32'(m_run));
  endtask

  task automatic idle_inputs();
    tick = 0; start = 0; pause = 0; load = 0; dir = 0; frog_in_lane = 0;
    frog_col = '0; load_pattern = '0;
    b_tick = 0; b_start = 0; b_pause = 0; b_load = 0; b_dir = 0; b_fil = 0;
    b_col = '0; b_pat = '0;
  endtask

  task automatic load_and_start(input logic [15:0] pat, input string tag);
    load = 1; load_pattern = pat; cyc({tag, ".ld"});
    load = 0; start = 1; cyc({tag, ".st"});
    start = 0;
  endtask

  initial begin
    logic [11:0] e2;
    int          hb;
    idle_inputs();
    reset = 1;
    model_reset();
    #2;
    check("rst.row",  32'(row_out),   32'h0003);
    check("rst.step", 32'(step),      32'h0);
    check("rst.coll", 32'(collision), 32'h0);
    check("rst.run",  32'(running),   32'h0);
    check("rst.row2", 32'(b_row),     32'hFFF);
    @(posedge clock); #1;
    reset = 0;

    // start then four ticks toward MSB: one shift, one step pulse
    start = 1; cyc("r39.st");
    start = 0; tick = 1;
    repeat (4) cyc("r39.tk");
    check("r39.row",  32'(row_out), 32'h0006);
    check("r39.step", 32'(step),    32'h1);
    tick = 0; cyc("r39.after");
    check("r39.step_once", 32'(step), 32'h0);

    // wrap toward LSB
    load_and_start(16'h0001, "r40");
    dir = 1; tick = 1;
    repeat (4) cyc("r40.tk");
    check("r40.row", 32'(row_out), 32'h8000);
    tick = 0; dir = 0;

    // collision freezes the lane; start and ticks ignored in HIT
    load_and_start(16'h0004, "r41");
    frog_col = 4'd2; frog_in_lane = 1; cyc("r41.hit");
    check("r41.coll", 32'(collision), 32'h1);
    check("r41.run",  32'(running),   32'h0);
    frog_in_lane = 0; tick = 1;
    repeat (8) cyc("r41.tk");
    start = 1; cyc("r41.start");
    start = 0; tick = 0;
    check("r41.row", 32'(row_out), 32'h0004);

    // pause discards ticks and holds the count
    load_and_start(16'h0001, "r42");
    tick = 1;
    repeat (2) cyc("r42.a");
    pause = 1;
    repeat (5) cyc("r42.p");
    pause = 0; cyc("r42.b3");
    check("r42.row3", 32'(row_out), 32'h0001);
    start = 1; cyc("r42.b4");
    start = 0;
    check("r42.row4",  32'(row_out), 32'h0002);
    check("r42.step4", 32'(step),    32'h1);
    tick = 0;

    // load beats a terminal tick
    load_and_start(16'h0001, "r43");
    tick = 1;
    repeat (3) cyc("r43.tk");
    load = 1; load_pattern = 16'h00F0; cyc("r43.ld");
    load = 0; tick = 0;
    check("r43.row",  32'(row_out),   32'h00F0);
    check("r43.step", 32'(step),      32'h0);
    check("r43.run",  32'(running),   32'h0);
    check("r43.coll", 32'(collision), 32'h0);

    // collision beats a terminal tick and uses the pre-shift row
    load_and_start(16'h0001, "r27");
    tick = 1;
    repeat (3) cyc("r27.tk");
    frog_in_lane = 1; frog_col = 4'd1; cyc("r27.miss");
    check("r27.shifted", 32'(row_out), 32'h0002);
    cyc("r27.hit");
    check("r27.coll", 32'(collision), 32'h1);
    load_and_start(16'h0001, "r27b");
    frog_in_lane = 0;
    repeat (3) cyc("r27b.tk");
    frog_in_lane = 1; frog_col = 4'd0; cyc("r27b.hit");
    check("r27b.row",  32'(row_out),   32'h0001);
    check("r27b.coll", 32'(collision), 32'h1);
    frog_in_lane = 0; tick = 0;

    // asynchronous reset between edges
    load_and_start(16'h0100, "r44");
    tick = 1;
    repeat (5) cyc("r44.tk");
    #3 reset = 1;
    #1;
    check("r44.row",  32'(row_out),   32'h0003);
    check("r44.run",  32'(running),   32'h0);
    check("r44.step", 32'(step),      32'h0);
    check("r44.coll", 32'(collision), 32'h0);
    model_reset();
    tick = 0;
    @(posedge clock); #1;
    reset = 0;

    // random traffic
    for (int i = 0; i < 600; i++) begin
      tick         = 1'($urandom_range(0, 1));
      pause        = ($urandom_range(0, 7) == 0);
      load         = ($urandom_range(0, 29) == 0);
      start        = ($urandom_range(0, 3) == 0);
      frog_in_lane = ($urandom_range(0, 7) == 0);
      frog_col     = 4'($urandom);
      load_pattern = 16'($urandom);
      if (i % 32 == 0) dir = 1'($urandom);
      cyc("rnd");
    end
    idle_inputs();

    // narrow lane: every-cycle shifting, out-of-lane frog never collides
    b_load = 1; b_pat = 12'h801;
    @(posedge clock); #1;
    b_load = 0; b_start = 1;
    @(posedge clock); #1;
    b_start = 0; b_tick = 1; b_fil = 1;
    e2 = 12'h801;
    for (int i = 0; i < 8; i++) begin
      b_col = 4'(12 + i % 4);
      @(posedge clock); #1;
      e2 = rotl12(e2);
      check("n.row",  32'(b_row),  32'(e2));
      check("n.step", 32'(b_step), 32'h1);
      check("n.coll", 32'(b_coll), 32'h0);
      check("n.run",  32'(b_run),  32'h1);
    end
    hb = 0;
    for (int k = 0; k < 12; k++) if (e2[k]) hb = k;
    b_col = 4'(hb);
    @(posedge clock); #1;
    check("n.hit.coll", 32'(b_coll), 32'h1);
    check("n.hit.run",  32'(b_run),  32'h0);
    check("n.hit.row",  32'(b_row),  32'(e2));
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
